// File: rtl/uart_tx_op_if.sv
// uart_tx_op_if: payload handshake between a producer and the uart_tx_op transmitter
interface uart_tx_op_if;
  logic [7:0] data_tx_i;
  logic       datatx_vld_i;
  logic       datatx_rdy_o;
  modport master (output data_tx_i, output datatx_vld_i, input datatx_rdy_o);
  modport slave (input data_tx_i, input datatx_vld_i, output datatx_rdy_o);
endinterface

// File: rtl/uart_tx_op.sv
// uart_tx_op: oversampled UART transmitter with 5-8 data bits, optional parity and 1/1.5/2 stop bits
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
module uart_tx_op (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_sample_i,
  input  logic [3:0] data_bit_num_i,
  input  logic [1:0] parity_type_i,
  input  logic [1:0] stop_bit_num_i,
  input  logic [7:0] oversample_rate_i,
  uart_tx_op_if.slave tx_if,
`ifdef UART_TX_BREAK_EN
  input  logic       break_i,
`endif
  output logic       uart_tx_o,
  output logic       busy_tx_o,
  output logic       tx_done_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t     r_state;
  logic [7:0] r_data, r_rate, r_cnt;
  logic [2:0] r_last, r_idx;
  logic [1:0] r_par, r_stop;
  logic       r_seg, r_tx, r_busy, r_done, r_rdy;
  logic [7:0] w_lim, w_mask;
  logic [3:0] w_dm1;
  logic [2:0] w_last;
  logic       w_end, w_par, w_brk;
`ifdef UART_TX_BREAK_EN
  assign w_brk = break_i;
`else
  assign w_brk = 1'b0;
`endif
  assign uart_tx_o = r_tx;
  assign busy_tx_o = r_busy;
  assign tx_done_o = r_done;
  assign tx_if.datatx_rdy_o = r_rdy;
  // The half stop segment of 1.5 stop bits is the only bit shorter than N pulses
  always_comb begin
    w_lim = (r_state == STOP && r_seg && r_stop == 2'b01) ? (r_rate >> 1) - 8'd1 : r_rate - 8'd1;
    w_end = clk_sample_i && r_cnt == w_lim;
    w_par = ^r_data ^ r_par[1];
    w_dm1 = data_bit_num_i - 4'd1;
    w_last = (data_bit_num_i >= 4'd5 && data_bit_num_i <= 4'd8) ? w_dm1[2:0] : 3'd7;
    w_mask = ~(8'hFE << w_last);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_data <= '0;
      r_rate <= '0;
      r_cnt <= '0;
      r_last <= '0;
      r_idx <= '0;
      r_par <= '0;
      r_stop <= '0;
      r_seg <= 1'b0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rdy <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && clk_sample_i) r_cnt <= w_end ? 8'd0 : r_cnt + 8'd1;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (r_rdy && tx_if.datatx_vld_i) begin
            r_data <= tx_if.data_tx_i & w_mask;
            r_last <= w_last;
            r_par <= (parity_type_i == 2'b11) ? 2'b00 : parity_type_i;
            r_stop <= (stop_bit_num_i == 2'b11) ? 2'b00 : stop_bit_num_i;
            r_rate <= (oversample_rate_i < 8'd2) ? 8'd2 : oversample_rate_i;
            r_cnt <= '0;
            r_state <= START;
            r_tx <= 1'b0;
            r_busy <= 1'b1;
            r_rdy <= 1'b0;
          end else begin
            r_rdy <= !w_brk;
            r_tx <= !w_brk;
          end
        end
        START: if (w_end) begin
          r_state <= DATA;
          r_idx <= '0;
          r_tx <= r_data[0];
        end
        DATA: if (w_end) begin
          if (r_idx == r_last) begin
            r_state <= (r_par != 2'b00) ? PARITY : STOP;
            r_tx <= (r_par != 2'b00) ? w_par : 1'b1;
            r_seg <= 1'b0;
          end else begin
            r_idx <= r_idx + 3'd1;
            r_tx <= r_data[r_idx + 3'd1];
          end
        end
        PARITY: if (w_end) begin
          r_state <= STOP;
          r_tx <= 1'b1;
          r_seg <= 1'b0;
        end
        STOP: if (w_end) begin
          if (!r_seg && r_stop != 2'b00) r_seg <= 1'b1;
          else begin
            r_state <= IDLE;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
